// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the sub-word memory initiator.
package mem_access_pkg;

    // Access size encoding as presented by the MEM stage.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Initiator FSM states.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StAccess = 2'b01,
        StWrite  = 2'b10,
        StDone   = 2'b11
    } state_e;

    // Little-endian byte lane selects (addr[1:0]).
    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // Alignment check; the reserved size is always an error.
    function automatic logic is_misaligned(size_e size, logic [1:0] lane);
        logic err;
        err = 1'b0;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = lane[0];
            SZ_WORD: err = (lane != LANE0);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane steering: load extract/extend and store merge.
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sign_ext,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        case (lane)
            LANE0:   byte_sel = rd_word[7:0];
            LANE1:   byte_sel = rd_word[15:8];
            LANE2:   byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    // Replace only the addressed lane of the old word with the new low bits.
    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    LANE0:   merged[7:0]   = new_data[7:0];
                    LANE1:   merged[15:8]  = new_data[7:0];
                    LANE2:   merged[23:16] = new_data[7:0];
                    default: merged[31:24] = new_data[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = new_data[15:0];
                else         merged[15:0]  = new_data[15:0];
            end
            default: merged = new_data;
        endcase
    end

endmodule

// File: rtl/subword_mem_initiator.sv
// Word-only bus initiator for byte/half/word loads and stores.
// Sub-word stores are done as read (ACCESS) then merged write (WRITE).
module subword_mem_initiator
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32  // lane logic assumes 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              misalign,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_writeEN,
    output logic [DATA_W-1:0] bus_writeData,
    input  logic [DATA_W-1:0] bus_readData
);

    state_e            state_q, state_d;
    logic              cap_write;
    size_e             cap_size;
    logic              cap_signed;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] merge_q;
    logic              err_q;

    logic              access_err;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;
    logic [ADDR_W-1:0] word_addr;
    logic              write_req;
    logic              done_pulse;

    assign access_err = is_misaligned(cap_size, cap_addr[1:0]);
    assign word_addr  = {cap_addr[ADDR_W-1:2], 2'b00};

    byte_lane_unit u_lane (
        .rd_word   (bus_readData),
        .old_word  (merge_q),
        .new_data  (cap_wdata),
        .lane      (cap_addr[1:0]),
        .size      (cap_size),
        .sign_ext  (cap_signed),
        .load_data (load_data),
        .merged    (merged)
    );

    // State register, request capture, load result and RMW merge register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cap_write  <= 1'b0;
            cap_size   <= SZ_BYTE;
            cap_signed <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            merge_q    <= '0;
            err_q      <= 1'b0;
            rdata      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        cap_write  <= req_write;
                        cap_size   <= size_e'(req_size);
                        cap_signed <= req_signed;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                    end
                end
                StAccess: begin
                    err_q   <= access_err;
                    merge_q <= bus_readData;
                    if (access_err)      rdata <= '0;
                    else if (!cap_write) rdata <= load_data;
                end
                default: ;
            endcase
        end
    end

    // Next state and bus/pipeline outputs; strobes are masked while in reset.
    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        bus_addr      = '0;
        bus_writeData = '0;
        write_req     = 1'b0;
        done_pulse    = 1'b0;
        case (state_q)
            StIdle: begin
                stall = req_valid;
                if (req_valid) state_d = StAccess;
            end
            StAccess: begin
                stall    = 1'b1;
                bus_addr = word_addr;
                if (access_err || !cap_write) begin
                    state_d = StDone;
                end else if (cap_size == SZ_WORD) begin
                    write_req     = 1'b1;
                    bus_writeData = cap_wdata;
                    state_d       = StDone;
                end else begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                stall         = 1'b1;
                bus_addr      = word_addr;
                write_req     = 1'b1;
                bus_writeData = merged;
                state_d       = StDone;
            end
            default: begin
                // Request still held by the pipeline here was already serviced.
                done_pulse = 1'b1;
                state_d    = StIdle;
            end
        endcase
        bus_writeEN = write_req & ~reset;
        rdata_valid = done_pulse & ~reset;
        misalign    = done_pulse & err_q & ~reset;
    end

endmodule

// File: tb/tb_subword_mem_initiator.sv
// Directed self-checking bench with a small word memory and an expected-result queue.
module tb_subword_mem_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rdata_valid, misalign, bus_writeEN;
    logic [31:0] rdata, bus_addr, bus_writeData, bus_readData;

    logic [31:0] mem [0:63];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_data;
    int          wr_count;
    int          addr_cycles;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;
    exp_t        sb_q [$];
    logic [31:0] exp_rdata;

    int n_checks;
    int n_pass;

    always #5 clk = ~clk;

    subword_mem_initiator #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .stall         (stall),
        .rdata         (rdata),
        .rdata_valid   (rdata_valid),
        .misalign      (misalign),
        .bus_addr      (bus_addr),
        .bus_writeEN   (bus_writeEN),
        .bus_writeData (bus_writeData),
        .bus_readData  (bus_readData)
    );

    assign bus_readData = mem[bus_addr[7:2]];

    // Memory model plus bus activity counters.
    always @(posedge clk) begin
        if (bus_writeEN) begin
            mem[bus_addr[7:2]] <= bus_writeData;
            wr_count           <= wr_count + 1;
        end else if (poke_en) begin
            mem[poke_idx] <= poke_data;
        end
        if (bus_addr != 32'h0) addr_cycles <= addr_cycles + 1;
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_load(logic [31:0] w, logic [1:0] a, logic [1:0] sz,
                                               logic sg);
        logic [31:0] sh;
        sh = w >> (8 * a);
        if (sz == 2'b00) return sg ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
        if (sz == 2'b01) return sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] model_merge(logic [31:0] old, logic [31:0] wd,
                                                logic [1:0] a, logic [1:0] sz);
        logic [31:0] m;
        if (sz == 2'b10) return wd;
        m = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * a);
        return (old & ~m) | ((wd << (8 * a)) & m);
    endfunction

    function automatic logic model_err(logic [1:0] sz, logic [1:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
    endfunction

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        poke_en   = 1'b1;
        poke_idx  = addr[7:2];
        poke_data = data;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // Issue one request, hold it through DONE, check latency, result and bus activity.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic        err;
        logic [31:0] old_word, exp_word;
        int          exp_stall, exp_wr, exp_ac, ns, wr0, ac0;
        exp_t        got;
        err      = model_err(sz, a[1:0]);
        old_word = mem[a[7:2]];
        exp_word = old_word;
        if (err) exp_rdata = 32'h0;
        else if (!w) exp_rdata = model_load(old_word, a[1:0], sz, sg);
        else exp_word = model_merge(old_word, wd, a[1:0], sz);
        sb_q.push_back('{rdata: exp_rdata, mis: err});
        exp_stall = (w && !err && sz != 2'b10) ? 3 : 2;
        exp_wr    = (w && !err) ? 1 : 0;
        exp_ac    = exp_stall - 1;
        wr0 = wr_count;
        ac0 = addr_cycles;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        ns = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) break;
            ns++;
        end
        chk(32'(ns), 32'(exp_stall), {tag, "_stall"});
        chk({31'h0, rdata_valid}, 32'h1, {tag, "_valid"});
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            chk(rdata, got.rdata, {tag, "_rdata"});
            chk({31'h0, misalign}, {31'h0, got.mis}, {tag, "_misalign"});
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk(32'(wr_count - wr0), 32'(exp_wr), {tag, "_writes"});
        chk(32'(addr_cycles - ac0), 32'(exp_ac), {tag, "_bus_cycles"});
        chk(mem[a[7:2]], exp_word, {tag, "_mem"});
    endtask

    initial begin
        int wr0;
        logic seen_valid;
        n_checks = 0; n_pass = 0;
        wr_count = 0; addr_cycles = 0;
        poke_en = 1'b0; poke_idx = '0; poke_data = '0;
        exp_rdata = 32'h0;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({31'h0, stall}, 32'h0, "rst_stall");
        chk(rdata, 32'h0, "rst_rdata");
        chk({31'h0, rdata_valid}, 32'h0, "rst_valid");
        chk({31'h0, misalign}, 32'h0, "rst_misalign");
        chk({31'h0, bus_writeEN}, 32'h0, "rst_we");
        chk(bus_addr, 32'h0, "rst_addr");
        chk(bus_writeData, 32'h0, "rst_wdata");
        @(posedge clk);
        #1 reset = 1'b0;

        // Loads and extension
        poke(32'h10, 32'hDEAD_BEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "ld_word");
        poke(32'h10, 32'h80FF_7F01);
        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "ld_sb13");
        run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "ld_ub13");
        run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, "ld_sh12");
        run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, "ld_sh10");
        run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, "ld_sb11");
        run_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, "ld_sw10");

        // Sub-word stores via read-modify-write
        poke(32'h20, 32'h1122_3344);
        run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFF_FFAB, "st_b21");
        run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234_BEEF, "st_h22");

        // Errors
        run_req(1'b1, 2'b01, 1'b0, 32'h23, 32'hAAAA_5555, "st_h23_err");
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "ld_reload");
        run_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h0000_0077, "st_rsvd_err");
        run_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, "ld_w22_err");

        // Reset while a byte store is in WRITE
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "ld_pre_rst");
        wr0 = wr_count;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0000_00CC;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({31'h0, bus_writeEN}, 32'h0, "rstw_we");
        @(posedge clk);
        #1 reset = 1'b0;
        exp_rdata = 32'h0;
        chk({31'h0, stall}, 32'h0, "rstw_stall");
        chk(rdata, 32'h0, "rstw_rdata");
        chk({31'h0, rdata_valid}, 32'h0, "rstw_valid");
        chk({31'h0, misalign}, 32'h0, "rstw_misalign");
        chk(bus_addr, 32'h0, "rstw_addr");
        chk(32'(wr_count - wr0), 32'h0, "rstw_writes");
        chk(mem[8], 32'hBEEF_AB44, "rstw_mem");
        seen_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_valid = seen_valid | rdata_valid;
        end
        chk({31'h0, seen_valid}, 32'h0, "rstw_no_pulse");
        @(posedge clk);
        #1;

        // Back-to-back IO store then load
        wr0 = wr_count;
        run_req(1'b1, 2'b10, 1'b0, 32'h84, 32'h0000_0005, "io_st");
        run_req(1'b0, 2'b10, 1'b0, 32'h84, 32'h0, "io_ld");
        chk(32'(wr_count - wr0), 32'h1, "io_total_writes");
        chk(32'(sb_q.size()), 32'h0, "sb_empty");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
